// File: rtl/seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// seq_match_ctrl
//
// Serial pattern matcher with a small run controller. A run is started from
// IDLE with a configuration (pattern, length, overlap mode, target count).
// While running, every qualified input bit is shifted into a history
// register and compared against the latched pattern. Each detected pattern
// produces a one-cycle match pulse and bumps a saturating match counter.
// When the counter reaches a nonzero target the run ends through DONE, which
// pulses done for one cycle before returning to IDLE. A run can also be
// ended early with abort, which never produces done.
//
// Parameters
//   MAXLEN      maximum pattern length in bits (2..15, limited by cfg_len)
//   CNTW        width of the match counter and target
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   reset       synchronous active-low reset
//   start       begin a run from IDLE, samples the cfg_* inputs
//   abort       end a run early, no done pulse
//   cfg_pattern pattern, bit cfg_len-1 is received first, bit 0 last
//   cfg_len     pattern length, legal range 1..MAXLEN
//   cfg_overlap 1 = overlapping detection, 0 = non-overlapping
//   cfg_target  matches that end the run, 0 = unlimited
//   x_valid     qualifies x
//   x           serial data bit
//   busy        high while in RUN
//   match       registered one-cycle pulse per detected pattern
//   match_count matches counted in the current or last run
//   done        one-cycle pulse after the target count is reached
//   cfg_err     one-cycle pulse when a start is rejected for a bad length
// ---------------------------------------------------------------------------
module seq_match_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              x_valid,
  input  logic              x,
  output logic              busy,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // MAXLEN expressed in the 4-bit domain of cfg_len and the fill counter.
  localparam logic [3:0] MAXLEN_L = 4'(MAXLEN);

  state_t              state_q, state_d;
  logic [MAXLEN-1:0]   hist_q, hist_d;
  logic [3:0]          fill_q, fill_d;
  logic [MAXLEN-1:0]   pat_q, pat_d;
  logic [3:0]          len_q, len_d;
  logic                ovl_q, ovl_d;
  logic [CNTW-1:0]     tgt_q, tgt_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                match_q, match_d;
  logic                err_q, err_d;

  logic [MAXLEN-1:0]   hist_shift;
  logic [MAXLEN-1:0]   len_mask;
  logic [3:0]          fill_inc;
  logic [CNTW-1:0]     cnt_inc;
  logic                len_ok;
  logic                window_hit;
  logic                bit_match;
  logic                hist_unused;

  // The oldest history bit is shifted out before it could ever be compared,
  // because the comparison looks at the history after the new bit is added.
  // It is kept so the history stays the full MAXLEN bits wide.
  assign hist_unused = hist_q[MAXLEN-1];

  // Datapath helpers shared by the next-state logic: the history with the
  // current bit appended, a saturating fill count, a saturating match count
  // and a mask selecting the low len_q history bits for the comparison.
  // Bits of the pattern above len_q are deliberately ignored so callers may
  // leave junk in the unused upper pattern bits.
  always_comb begin
    hist_shift = {hist_q[MAXLEN-2:0], x};
    fill_inc   = (fill_q == MAXLEN_L) ? fill_q : fill_q + 4'd1;
    cnt_inc    = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);
    len_ok     = (cfg_len != 4'd0) && (cfg_len <= MAXLEN_L);
    len_mask   = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      len_mask[i] = (4'(i) < len_q);
    end
    window_hit = (((hist_shift ^ pat_q) & len_mask) == '0);
    bit_match  = (fill_inc >= len_q) && window_hit;
  end

  // Next-state and next-register logic for the run controller. Everything
  // holds by default; the pulse registers default low so they only ever
  // stay high for one cycle. In RUN, abort is checked before the data bit so
  // that a bit arriving with abort is thrown away even if it would complete
  // a match. In non-overlapping mode the fill count restarts after a match
  // so no bit of a matched window can contribute to the next match.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            tgt_d   = cfg_target;
            cnt_d   = '0;
            hist_d  = '0;
            fill_d  = 4'd0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (x_valid) begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (bit_match) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if (!ovl_q) begin
              fill_d = 4'd0;
            end
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register update. Reset is synchronous and active-low; it
  // wins over every other input, including in the middle of a run, and
  // clears the latched configuration as well as the counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= 4'd0;
      pat_q   <= '0;
      len_q   <= 4'd0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from registers: busy and done decode the state,
  // the pulses and count are their own flops.
  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    match       = match_q;
    match_count = cnt_q;
    cfg_err     = err_q;
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_match_ctrl
//
// Directed bench for seq_match_ctrl with MAXLEN=8, CNTW=8. A table of
// per-cycle input records with hand-computed expected outputs is built up
// front, then each record is driven for one clock and the outputs compared
// one time unit after the rising edge. A hand-written sequence afterwards
// drives a long run to check match counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_match_ctrl;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
    logic       xv;
    logic       xb;
    logic       e_busy;
    logic       e_match;
    logic [7:0] e_cnt;
    logic       e_done;
    logic       e_err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       x_valid;
  logic       x;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       done;
  logic       cfg_err;

  vec_t       vecs[$];
  logic [7:0] cur_pat;
  logic [3:0] cur_len;
  logic       cur_ovl;
  logic [7:0] cur_tgt;
  int         check_cnt;
  int         pass_cnt;

  seq_match_ctrl #(
    .MAXLEN(8),
    .CNTW  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .x_valid    (x_valid),
    .x          (x),
    .busy       (busy),
    .match      (match),
    .match_count(match_count),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Configuration captured into every row added after this call.
  task automatic setCfg(input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic [7:0] t);
    cur_pat = p;
    cur_len = l;
    cur_ovl = o;
    cur_tgt = t;
  endtask

  // One table row: inputs for one clock and the outputs expected after it.
  task automatic addRow(input logic r, input logic s, input logic a,
                        input logic xv, input logic xb,
                        input logic eb, input logic em, input logic [7:0] ec,
                        input logic ed, input logic ee);
    vec_t v;
    v.rst_n = r;    v.start = s;     v.abort = a;
    v.pat   = cur_pat; v.len = cur_len; v.ovl = cur_ovl; v.tgt = cur_tgt;
    v.xv    = xv;   v.xb = xb;
    v.e_busy = eb;  v.e_match = em; v.e_cnt = ec; v.e_done = ed; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Drive one record's inputs, let one rising edge pass, then settle.
  task automatic applyStimulus(input vec_t v);
    reset       = v.rst_n;
    start       = v.start;
    abort       = v.abort;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    cfg_target  = v.tgt;
    x_valid     = v.xv;
    x           = v.xb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input int row,
                            input logic [7:0] act, input logic [7:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    checkValue("busy",        row, {7'd0, busy},    {7'd0, v.e_busy});
    checkValue("match",       row, {7'd0, match},   {7'd0, v.e_match});
    checkValue("match_count", row, match_count,     v.e_cnt);
    checkValue("done",        row, {7'd0, done},    {7'd0, v.e_done});
    checkValue("cfg_err",     row, {7'd0, cfg_err}, {7'd0, v.e_err});
  endtask

  initial begin
    vec_t v;
    check_cnt = 0;
    pass_cnt  = 0;

    // ---- table: r  s  a  xv x  | busy match cnt done err ----
    setCfg(8'h00, 4'd4, 1'b0, 8'd0);
    addRow(0, 0, 0, 0, 0,  0, 0, 8'd0, 0, 0);   // reset state

    // Case 1: 0110 non-overlapping, stream 0,1,1,0,1,1,0
    setCfg(8'h06, 4'd4, 1'b0, 8'd0);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 1, 8'd1, 0, 0);
    setCfg(8'hFF, 4'd0, 1'b1, 8'd1);             // start with junk cfg in RUN is ignored
    addRow(1, 1, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 1, 0, 0,  0, 0, 8'd1, 0, 0);   // abort, count kept
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd1, 0, 0);
    addRow(1, 0, 1, 1, 1,  0, 0, 8'd1, 0, 0);   // abort in IDLE: no effect

    // Case 2: same stream, overlapping
    setCfg(8'h06, 4'd4, 1'b1, 8'd0);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 1, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 1, 8'd2, 0, 0);
    addRow(1, 0, 1, 0, 0,  0, 0, 8'd2, 0, 0);

    // Case 3: 11 overlapping, target 3, gaps carry x=0 with x_valid=0
    setCfg(8'h03, 4'd2, 1'b1, 8'd3);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 1, 8'd1, 0, 0);
    addRow(1, 0, 0, 0, 0,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 1, 8'd2, 0, 0);
    addRow(1, 0, 0, 1, 1,  0, 1, 8'd3, 1, 0);   // DONE
    addRow(1, 0, 1, 1, 1,  0, 0, 8'd3, 0, 0);   // abort in DONE: no effect
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd3, 0, 0);

    // Case 4: rejected starts
    setCfg(8'h06, 4'd0, 1'b0, 8'd0);
    addRow(1, 1, 0, 0, 0,  0, 0, 8'd3, 0, 1);
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd3, 0, 0);
    setCfg(8'h06, 4'd9, 1'b0, 8'd0);
    addRow(1, 1, 0, 0, 0,  0, 0, 8'd3, 0, 1);
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd3, 0, 0);

    // Case 5: abort on the completing bit of 0110 (overlapping, one prior match)
    setCfg(8'h06, 4'd4, 1'b1, 8'd0);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 1, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);
    addRow(1, 0, 1, 1, 0,  0, 0, 8'd1, 0, 0);   // abort beats match
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd1, 0, 0);

    // Case 6: reset mid-run at count 2, then immediate restart
    setCfg(8'h03, 4'd2, 1'b0, 8'd0);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 1, 8'd1, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd1, 0, 0);   // fill restarted, no reuse
    addRow(1, 0, 0, 1, 1,  1, 1, 8'd2, 0, 0);
    addRow(0, 1, 1, 1, 1,  0, 0, 8'd0, 0, 0);   // reset wins over everything
    // asymmetric pattern 100 (first 1) with junk in the upper pattern bits
    setCfg(8'hF4, 4'd3, 1'b1, 8'd1);
    addRow(1, 1, 0, 0, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 1,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  1, 0, 8'd0, 0, 0);
    addRow(1, 0, 0, 1, 0,  0, 1, 8'd1, 1, 0);
    addRow(1, 0, 0, 0, 0,  0, 0, 8'd1, 0, 0);

    $display("[TB] applying %0d table rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Hand-written: single-bit pattern 1, overlapping, 260 ones in a row.
    // Every bit matches; the count climbs to 255 and then sticks there.
    setCfg(8'h01, 4'd1, 1'b1, 8'd0);
    v.rst_n = 1'b1; v.start = 1'b1; v.abort = 1'b0;
    v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl; v.tgt = cur_tgt;
    v.xv = 1'b0; v.xb = 1'b0;
    applyStimulus(v);
    checkValue("sat_start_busy", 0, {7'd0, busy}, 8'd1);
    v.start = 1'b0; v.xv = 1'b1; v.xb = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      applyStimulus(v);
      if (n == 10)  checkValue("sat_cnt_10",  n, match_count, 8'd10);
      if (n == 255) checkValue("sat_cnt_255", n, match_count, 8'd255);
    end
    checkValue("sat_cnt_end",   260, match_count, 8'd255);
    checkValue("sat_match_end", 260, {7'd0, match}, 8'd1);
    checkValue("sat_busy_end",  260, {7'd0, busy},  8'd1);
    v.abort = 1'b1; v.xv = 1'b0;
    applyStimulus(v);
    checkValue("sat_abort_busy", 261, {7'd0, busy}, 8'd0);
    checkValue("sat_abort_cnt",  261, match_count, 8'd255);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
